// File: rtl/pending_drain.sv
// Batch serializer: captures N tagged entries + mask, issues pending entries one per cycle (lowest index first, or highest when REVERSE=1).
// Latency: first entry is presented the cycle after batch accept; one entry per cycle at full out_ready.
// Backpressure: outputs are held while out_ready is low; a new batch is taken only when idle or on the last handshake. Optional perf counters: PENDING_DRAIN_PERF_EN.
module pending_drain #(
    parameter int N       = 4,
    parameter int DATAW   = 8,
    parameter int REVERSE = 0,
    parameter int LOGN    = (N > 1) ? $clog2(N) : 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N-1:0]         in_mask,
    input  logic [N*DATAW-1:0]   in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATAW-1:0]     out_data,
    output logic [LOGN-1:0]      out_index,
    output logic                 out_last
`ifdef PENDING_DRAIN_PERF_EN
    ,
    output logic [31:0]          perf_stalls,
    output logic [31:0]          perf_batches
`endif
);

    logic [N-1:0]            pmask_q, pmask_d;
    logic [N-1:0][DATAW-1:0] dreg_q;
    logic [LOGN-1:0]         sel;
    logic [N-1:0]            sel_oh;
    logic                    handshake;
    logic                    accept;

    // Later iterations override earlier ones, so the scan order picks the winner.
    always_comb begin
        sel    = '0;
        sel_oh = '0;
        if (REVERSE != 0) begin
            for (int i = 0; i < N; i++) begin
                if (pmask_q[i]) begin
                    sel       = LOGN'(i);
                    sel_oh    = '0;
                    sel_oh[i] = 1'b1;
                end
            end
        end else begin
            for (int i = N - 1; i >= 0; i--) begin
                if (pmask_q[i]) begin
                    sel       = LOGN'(i);
                    sel_oh    = '0;
                    sel_oh[i] = 1'b1;
                end
            end
        end
    end

    assign out_valid = |pmask_q;
    assign out_index = sel;
    assign out_data  = dreg_q[sel];
    assign out_last  = out_valid && ((pmask_q & ~sel_oh) == '0);
    assign handshake = out_valid & out_ready;
    assign in_ready  = ~out_valid | (handshake & out_last);
    assign accept    = in_valid & in_ready;

    // A batch arriving on the last handshake replaces the clear of the final bit.
    always_comb begin
        pmask_d = pmask_q;
        if (accept) begin
            pmask_d = in_mask;
        end else if (handshake) begin
            pmask_d = pmask_q & ~sel_oh;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pmask_q <= '0;
        end else begin
            pmask_q <= pmask_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            for (int i = 0; i < N; i++) begin
                dreg_q[i] <= in_data[i*DATAW +: DATAW];
            end
        end
    end

`ifdef PENDING_DRAIN_PERF_EN
    logic [31:0] stalls_q, batches_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stalls_q  <= '0;
            batches_q <= '0;
        end else begin
            if (out_valid && !out_ready && !(&stalls_q)) begin
                stalls_q <= stalls_q + 32'd1;
            end
            if (accept && (|in_mask) && !(&batches_q)) begin
                batches_q <= batches_q + 32'd1;
            end
        end
    end

    assign perf_stalls  = stalls_q;
    assign perf_batches = batches_q;
`endif

endmodule

// File: tb/tb_pending_drain.sv
// Directed bench for pending_drain: forward and reverse instances share stimulus; per-cycle vector table plus a mid-drain reset sequence.
module tb_pending_drain;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic [3:0]  in_mask;
    logic [31:0] in_data;
    logic        out_ready;

    logic        f_in_ready, f_out_valid, f_out_last;
    logic [7:0]  f_out_data;
    logic [1:0]  f_out_index;
    logic        r_in_ready, r_out_valid, r_out_last;
    logic [7:0]  r_out_data;
    logic [1:0]  r_out_index;
`ifdef PENDING_DRAIN_PERF_EN
    logic [31:0] f_perf_stalls, f_perf_batches, r_perf_stalls, r_perf_batches;
`endif

    always #5 clk = ~clk;

    pending_drain #(.N(4), .DATAW(8), .REVERSE(0)) u_fwd (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(f_in_ready), .in_mask(in_mask), .in_data(in_data),
        .out_valid(f_out_valid), .out_ready(out_ready), .out_data(f_out_data),
        .out_index(f_out_index), .out_last(f_out_last)
`ifdef PENDING_DRAIN_PERF_EN
        , .perf_stalls(f_perf_stalls), .perf_batches(f_perf_batches)
`endif
    );

    pending_drain #(.N(4), .DATAW(8), .REVERSE(1)) u_rev (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(r_in_ready), .in_mask(in_mask), .in_data(in_data),
        .out_valid(r_out_valid), .out_ready(out_ready), .out_data(r_out_data),
        .out_index(r_out_index), .out_last(r_out_last)
`ifdef PENDING_DRAIN_PERF_EN
        , .perf_stalls(r_perf_stalls), .perf_batches(r_perf_batches)
`endif
    );

    typedef struct {
        logic        iv;
        logic [3:0]  m;
        logic [31:0] d;
        logic        rdy;
        logic        ov;
        logic        ir;
        logic [1:0]  idx;
        logic [7:0]  dat;
        logic        last;
        logic [1:0]  ridx;
        logic [7:0]  rdat;
        logic        rlast;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;
    vec_t vq[$];

    localparam logic [31:0] DA  = 32'h33221100;
    localparam logic [31:0] DX  = 32'hAABBCCDD;
    localparam logic [31:0] DA2 = 32'h44556677;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic iv, input logic [3:0] m, input logic [31:0] d,
                                input logic rdy, input logic ov, input logic ir,
                                input logic [1:0] idx, input logic [7:0] dat, input logic last,
                                input logic [1:0] ridx, input logic [7:0] rdat, input logic rlast);
        vec_t v;
        v.iv = iv; v.m = m; v.d = d; v.rdy = rdy; v.ov = ov; v.ir = ir;
        v.idx = idx; v.dat = dat; v.last = last;
        v.ridx = ridx; v.rdat = rdat; v.rlast = rlast;
        return v;
    endfunction

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_mask   = '0;
        in_data   = '0;
        out_ready = 1'b1;

        // Basic drain of 1010 (forward 1,3 / reverse 3,1)
        vq.push_back(mk(1, 4'b1010, DA, 1,  0, 1,  0, 8'h00, 0,  0, 8'h00, 0));
        vq.push_back(mk(0, 4'b0000, DA, 1,  1, 0,  1, 8'h11, 0,  3, 8'h33, 0));
        vq.push_back(mk(0, 4'b0000, DA, 1,  1, 1,  3, 8'h33, 1,  1, 8'h11, 1));
        vq.push_back(mk(0, 4'b0000, DA, 1,  0, 1,  0, 8'h00, 0,  0, 8'h00, 0));
        // Full mask with a 3-cycle stall; a competing batch offered during the stall is ignored
        vq.push_back(mk(1, 4'b1111, DA, 1,  0, 1,  0, 8'h00, 0,  0, 8'h00, 0));
        for (int k = 0; k < 3; k++)
            vq.push_back(mk(1, 4'b0001, DX, 0,  1, 0,  0, 8'h00, 0,  3, 8'h33, 0));
        vq.push_back(mk(0, 4'b0000, DX, 1,  1, 0,  0, 8'h00, 0,  3, 8'h33, 0));
        vq.push_back(mk(0, 4'b0000, DX, 1,  1, 0,  1, 8'h11, 0,  2, 8'h22, 0));
        vq.push_back(mk(0, 4'b0000, DX, 1,  1, 0,  2, 8'h22, 0,  1, 8'h11, 0));
        vq.push_back(mk(0, 4'b0000, DX, 1,  1, 1,  3, 8'h33, 1,  0, 8'h00, 1));
        vq.push_back(mk(0, 4'b0000, DX, 1,  0, 1,  0, 8'h00, 0,  0, 8'h00, 0));
        // Back-to-back: A=0001 then B=0100 taken on A's last handshake
        vq.push_back(mk(1, 4'b0001, DA2, 1, 0, 1,  0, 8'h00, 0,  0, 8'h00, 0));
        vq.push_back(mk(1, 4'b0100, DA, 1,  1, 1,  0, 8'h77, 1,  0, 8'h77, 1));
        vq.push_back(mk(0, 4'b0000, DA, 1,  1, 1,  2, 8'h22, 1,  2, 8'h22, 1));
        vq.push_back(mk(0, 4'b0000, DA, 1,  0, 1,  0, 8'h00, 0,  0, 8'h00, 0));
        // Empty batch
        vq.push_back(mk(1, 4'b0000, DA, 1,  0, 1,  0, 8'h00, 0,  0, 8'h00, 0));
        vq.push_back(mk(0, 4'b0000, DA, 1,  0, 1,  0, 8'h00, 0,  0, 8'h00, 0));
        vq.push_back(mk(0, 4'b0000, DA, 1,  0, 1,  0, 8'h00, 0,  0, 8'h00, 0));

        #2;
        chk("reset out_valid fwd", {31'd0, f_out_valid}, 32'd0);
        chk("reset in_ready fwd",  {31'd0, f_in_ready},  32'd1);
        chk("reset out_valid rev", {31'd0, r_out_valid}, 32'd0);
`ifdef PENDING_DRAIN_PERF_EN
        chk("reset perf_stalls",  f_perf_stalls,  32'd0);
        chk("reset perf_batches", f_perf_batches, 32'd0);
`endif
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            in_valid  = vq[i].iv;
            in_mask   = vq[i].m;
            in_data   = vq[i].d;
            out_ready = vq[i].rdy;
            #1;
            chk($sformatf("v%0d out_valid fwd", i), {31'd0, f_out_valid}, {31'd0, vq[i].ov});
            chk($sformatf("v%0d out_valid rev", i), {31'd0, r_out_valid}, {31'd0, vq[i].ov});
            chk($sformatf("v%0d in_ready fwd", i),  {31'd0, f_in_ready},  {31'd0, vq[i].ir});
            chk($sformatf("v%0d in_ready rev", i),  {31'd0, r_in_ready},  {31'd0, vq[i].ir});
            if (vq[i].ov) begin
                chk($sformatf("v%0d index fwd", i), {30'd0, f_out_index}, {30'd0, vq[i].idx});
                chk($sformatf("v%0d data fwd", i),  {24'd0, f_out_data},  {24'd0, vq[i].dat});
                chk($sformatf("v%0d last fwd", i),  {31'd0, f_out_last},  {31'd0, vq[i].last});
                chk($sformatf("v%0d index rev", i), {30'd0, r_out_index}, {30'd0, vq[i].ridx});
                chk($sformatf("v%0d data rev", i),  {24'd0, r_out_data},  {24'd0, vq[i].rdat});
                chk($sformatf("v%0d last rev", i),  {31'd0, r_out_last},  {31'd0, vq[i].rlast});
            end
        end

`ifdef PENDING_DRAIN_PERF_EN
        chk("perf_stalls fwd",  f_perf_stalls,  32'd3);
        chk("perf_batches fwd", f_perf_batches, 32'd4);
        chk("perf_batches rev", r_perf_batches, 32'd4);
`endif

        // Asynchronous reset mid-drain after one handshake
        @(negedge clk);
        in_valid = 1'b1; in_mask = 4'b1111; in_data = DA; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("rst seq first index", {30'd0, f_out_index}, 32'd0);
        @(negedge clk);
        #1;
        chk("rst seq second valid", {31'd0, f_out_valid}, 32'd1);
        chk("rst seq second index", {30'd0, f_out_index}, 32'd1);
        reset_n = 1'b0;
        #1;
        chk("async rst out_valid fwd", {31'd0, f_out_valid}, 32'd0);
        chk("async rst in_ready fwd",  {31'd0, f_in_ready},  32'd1);
        chk("async rst out_valid rev", {31'd0, r_out_valid}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            chk($sformatf("post rst idle %0d", k), {31'd0, f_out_valid | r_out_valid}, 32'd0);
        end
        @(negedge clk);
        in_valid = 1'b1; in_mask = 4'b0010; in_data = DX;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("post rst new index", {30'd0, f_out_index}, 32'd1);
        chk("post rst new data",  {24'd0, f_out_data},  32'h000000CC);
        chk("post rst new last",  {31'd0, f_out_last},  32'd1);
        @(negedge clk);
        #1;
        chk("post rst drained", {31'd0, f_out_valid}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
